// File: rtl/adc_pkt_rx_pkg.sv
// Shared types and constants for the ADC packet receiver.
// Holds the FSM state encoding, the err_status bit positions and the
// mapping from the cfg_data_length code to a packet length in words.
package adc_pkt_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // Longest packet; the word counter is sized to hold it.
  localparam int MAX_LEN = 1728;
  localparam int WCW     = $clog2(MAX_LEN + 1);

  // err_status bit positions
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_GAP   = 2;
  localparam int ERR_PAT   = 3;

  // 0 -> 216, 1 -> 432, 2 -> 864, 3 -> 1728 words
  function automatic logic [WCW-1:0] pkt_len(input logic [1:0] sel);
    return WCW'(216) << sel;
  endfunction

endpackage

// File: rtl/adc_pkt_pat_chk.sv
// Per-packet incrementing-pattern checker: each word after SOP must be previous+1.
// Ports: clk_i/rst_i; en_i (self-test, latched at SOP); vld_i/sop_i/dat_i (accepted word);
//        first_mis_o (pulse on the first mismatch of a packet); err_o (packet has mismatched so far).
module adc_pkt_pat_chk #(
  parameter int DW = 18
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          vld_i,
  input  logic          sop_i,
  input  logic [DW-1:0] dat_i,
  output logic          first_mis_o,
  output logic          err_o
);

  logic [DW-1:0] prev_q, prev_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic          mis;

  // The SOP word only seeds the reference; it can never mismatch.
  assign mis         = vld_i & ~sop_i & en_q & (dat_i != (prev_q + DW'(1)));
  assign first_mis_o = mis & ~err_q;
  // err_q already includes the most recently accepted word, which is what the
  // top needs when it closes the packet one cycle after that word.
  assign err_o       = err_q;

  always_comb begin
    prev_d = prev_q;
    en_d   = en_q;
    err_d  = err_q;
    if (vld_i) begin
      prev_d = dat_i;
      if (sop_i) begin
        en_d  = en_i;
        err_d = 1'b0;
      end else begin
        err_d = err_q | mis;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      en_q   <= en_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/adc_pkt_rx.sv
// ADC pad-stream receiver: frames valid bursts into SOP/EOP packets and checks length, gap and
// (with ADC_PKT_RX_PATTERN_CHK_EN defined) the incrementing self-test pattern.
// Ports: clk/rst; rx_en; adc_data/adc_data_valid (pad); cfg_* (length code, min idle, self-test);
//        err_clr/cnt_clr pulses; pkt_* stream out (2-cycle latency); pkt_cnt/err_cnt/err_status.
module adc_pkt_rx
  import adc_pkt_rx_pkg::*;
#(
  parameter int DW   = 18,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_en,
  input  logic [DW-1:0]   adc_data,
  input  logic            adc_data_valid,
  input  logic [1:0]      cfg_data_length,
  input  logic [7:0]      cfg_idle_length,
  input  logic            cfg_self_test,
  input  logic            err_clr,
  input  logic            cnt_clr,
  output logic [DW-1:0]   pkt_data,
  output logic            pkt_valid,
  output logic            pkt_sop,
  output logic            pkt_eop,
  output logic            pkt_err,
  output logic [CNTW-1:0] pkt_cnt,
  output logic [CNTW-1:0] err_cnt,
  output logic [3:0]      err_status
);

  state_e         state_q, state_d;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic [WCW-1:0] len_q, len_d;
  logic [7:0]     gap_q, gap_d;
  logic           armed_q, armed_d;
  logic           gerr_q, gerr_d;

  // Stage 1 holds the word accepted last cycle until we know whether it ends the packet.
  logic [DW-1:0]  s1_dat_q;
  logic           s1_sop_q;

  logic [DW-1:0]   pkt_data_q;
  logic            pkt_valid_q, pkt_sop_q, pkt_eop_q, pkt_err_q;
  logic [CNTW-1:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [3:0]      err_status_q, err_status_d;

  logic acc, sop, eop, long_err, short_err, gap_err;
  logic pat_first, pat_err, in_data, err_c;
  logic [3:0] set_bits;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    gap_d     = gap_q;
    armed_d   = armed_q;
    gerr_d    = gerr_q;
    acc       = 1'b0;
    sop       = 1'b0;
    eop       = 1'b0;
    long_err  = 1'b0;
    short_err = 1'b0;
    gap_err   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_en) begin
          if (adc_data_valid) begin
            // Joined mid-burst: discard the rest of it quietly.
            state_d = ST_DROP;
          end else begin
            state_d = ST_GAP;
            armed_d = 1'b0;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (!rx_en) begin
          state_d = ST_IDLE;
        end else if (adc_data_valid) begin
          acc     = 1'b1;
          sop     = 1'b1;
          gap_err = armed_q && (gap_q < cfg_idle_length);
          gerr_d  = gap_err;
          len_d   = pkt_len(cfg_data_length);
          cnt_d   = WCW'(1);
          state_d = ST_DATA;
        end else if (gap_q != 8'hFF) begin
          gap_d = gap_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == len_q) begin
          // Nth word already taken; valid still high means the burst overran.
          eop      = 1'b1;
          long_err = adc_data_valid;
          state_d  = adc_data_valid ? ST_DROP : ST_GAP;
          armed_d  = 1'b1;
          gap_d    = 8'd1;
        end else if (adc_data_valid) begin
          acc   = 1'b1;
          cnt_d = cnt_q + WCW'(1);
        end else begin
          // This idle cycle is the first of the following gap.
          eop       = 1'b1;
          short_err = 1'b1;
          state_d   = ST_GAP;
          armed_d   = 1'b1;
          gap_d     = 8'd1;
        end
      end
      ST_DROP: begin
        if (!adc_data_valid) begin
          state_d = ST_GAP;
          armed_d = 1'b1;
          gap_d   = 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ADC_PKT_RX_PATTERN_CHK_EN
  adc_pkt_pat_chk #(.DW(DW)) u_pat_chk (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (cfg_self_test),
    .vld_i       (acc),
    .sop_i       (sop),
    .dat_i       (adc_data),
    .first_mis_o (pat_first),
    .err_o       (pat_err)
  );
`else
  logic unused_self_test;
  assign unused_self_test = cfg_self_test;
  assign pat_first        = 1'b0;
  assign pat_err          = 1'b0;
`endif

  assign in_data = (state_q == ST_DATA);
  assign err_c   = gerr_q | pat_err | long_err | short_err;

  always_comb begin
    set_bits            = '0;
    set_bits[ERR_SHORT] = short_err;
    set_bits[ERR_LONG]  = long_err;
    set_bits[ERR_GAP]   = gap_err;
    set_bits[ERR_PAT]   = pat_first;
    // A flag raised in the clearing cycle survives the clear.
    err_status_d = err_clr ? set_bits : (err_status_q | set_bits);

    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end else if (eop) begin
      if (!err_c && !(&pkt_cnt_q)) pkt_cnt_d = pkt_cnt_q + CNTW'(1);
      if (err_c && !(&err_cnt_q))  err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      armed_q      <= 1'b0;
      gerr_q       <= 1'b0;
      s1_dat_q     <= '0;
      s1_sop_q     <= 1'b0;
      pkt_data_q   <= '0;
      pkt_valid_q  <= 1'b0;
      pkt_sop_q    <= 1'b0;
      pkt_eop_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
      err_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      armed_q      <= armed_d;
      gerr_q       <= gerr_d;
      if (acc) begin
        s1_dat_q <= adc_data;
        s1_sop_q <= sop;
      end
      pkt_data_q   <= s1_dat_q;
      pkt_valid_q  <= in_data;
      pkt_sop_q    <= in_data & s1_sop_q;
      pkt_eop_q    <= eop;
      pkt_err_q    <= eop & err_c;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_status_q <= err_status_d;
    end
  end

  assign pkt_data   = pkt_data_q;
  assign pkt_valid  = pkt_valid_q;
  assign pkt_sop    = pkt_sop_q;
  assign pkt_eop    = pkt_eop_q;
  assign pkt_err    = pkt_err_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_status = err_status_q;

endmodule

// File: tb/tb_adc_pkt_rx.sv
// Testbench for adc_pkt_rx: scoreboard of expected output words fed by a burst-level model,
// popped by an independent monitor; counters and sticky flags compared at phase boundaries.
module tb_adc_pkt_rx;

  localparam int DW   = 18;
  localparam int CNTW = 16;
`ifdef ADC_PKT_RX_PATTERN_CHK_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, rx_en, adc_data_valid, cfg_self_test, err_clr, cnt_clr;
  logic [DW-1:0]   adc_data;
  logic [1:0]      cfg_data_length;
  logic [7:0]      cfg_idle_length;
  logic [DW-1:0]   pkt_data;
  logic            pkt_valid, pkt_sop, pkt_eop, pkt_err;
  logic [CNTW-1:0] pkt_cnt, err_cnt;
  logic [3:0]      err_status;

  always #5 clk = ~clk;

  adc_pkt_rx #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .adc_data(adc_data), .adc_data_valid(adc_data_valid),
    .cfg_data_length(cfg_data_length), .cfg_idle_length(cfg_idle_length),
    .cfg_self_test(cfg_self_test), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_err(pkt_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err_status(err_status)
  );

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   first_pad = -1;
  int   first_out = -1;

  // Burst-level model state
  int       m_pkt, m_err, idle_run;
  logic [3:0] m_status;
  bit       m_armed;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && pkt_valid) begin
      if (first_out < 0) first_out = cyc;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data=%h sop=%b eop=%b, required no output",
                 pkt_data, pkt_sop, pkt_eop);
      end else begin
        mon_e = exp_q.pop_front();
        if (pkt_data !== mon_e.dat || pkt_sop !== mon_e.sop || pkt_eop !== mon_e.eop ||
            (mon_e.eop && pkt_err !== mon_e.err)) begin
          n_fail++;
          $display("FAIL pkt_word: got data=%h sop=%b eop=%b err=%b, required data=%h sop=%b eop=%b err=%b",
                   pkt_data, pkt_sop, pkt_eop, pkt_err, mon_e.dat, mon_e.sop, mon_e.eop, mon_e.err);
        end
      end
    end
  end

  task automatic cmp(input string nm, input longint got, input longint req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      adc_data_valid = 1'b0;
      adc_data       = DW'($urandom);
      tick();
      idle_run++;
    end
  endtask

  // Expected outcome of one burst, from the framing rules alone.
  function automatic void model_burst(input logic [DW-1:0] d[$]);
    int n    = 216 << cfg_data_length;
    int len  = d.size();
    int m    = (len < n) ? len : n;
    int g    = (idle_run > 255) ? 255 : idle_run;
    bit gap_e = m_armed && (g < int'(cfg_idle_length));
    bit pat_e = 1'b0;
    bit err;
    exp_t e;
    if (PAT_EN && cfg_self_test)
      for (int i = 1; i < m; i++)
        if (d[i] !== DW'(d[i-1] + 1)) pat_e = 1'b1;
    err = gap_e | pat_e | (len != n);
    for (int i = 0; i < m; i++) begin
      e.dat = d[i];
      e.sop = (i == 0);
      e.eop = (i == m - 1);
      e.err = err;
      exp_q.push_back(e);
    end
    if (len < n) m_status[0] = 1'b1;
    if (len > n) m_status[1] = 1'b1;
    if (gap_e)   m_status[2] = 1'b1;
    if (pat_e)   m_status[3] = 1'b1;
    if (err) m_err++; else m_pkt++;
    m_armed = 1'b1;
  endfunction

  task automatic send_burst(input int len, input int start, input int cidx, input logic [DW-1:0] cval);
    logic [DW-1:0] d[$];
    for (int i = 0; i < len; i++) d.push_back(DW'(start + i));
    if (cidx >= 0 && cidx < len) d[cidx] = cval;
    model_burst(d);
    for (int i = 0; i < len; i++) begin
      adc_data_valid = 1'b1;
      adc_data       = d[i];
      if (first_pad < 0) first_pad = cyc;
      tick();
    end
    idle_run = 0;
  endtask

  task automatic check_regs(input string tag);
    idle(6);
    cmp({tag, "_pkt_cnt"}, pkt_cnt, m_pkt);
    cmp({tag, "_err_cnt"}, err_cnt, m_err);
    cmp({tag, "_err_status"}, err_status, m_status);
  endtask

  task automatic clear_all();
    err_clr = 1'b1;
    cnt_clr = 1'b1;
    idle(1);
    err_clr  = 1'b0;
    cnt_clr  = 1'b0;
    m_status = '0;
    m_pkt    = 0;
    m_err    = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rx_en = 1'b0; adc_data_valid = 1'b0; adc_data = '0;
    cfg_data_length = 2'd1; cfg_idle_length = 8'd15; cfg_self_test = 1'b1;
    err_clr = 1'b0; cnt_clr = 1'b0;
    m_pkt = 0; m_err = 0; m_status = '0; m_armed = 1'b0; idle_run = 0;
    repeat (3) tick();
    cmp("rst_pkt_valid", pkt_valid, 0);
    cmp("rst_pkt_sop", pkt_sop, 0);
    cmp("rst_pkt_eop", pkt_eop, 0);
    cmp("rst_pkt_err", pkt_err, 0);
    cmp("rst_pkt_data", pkt_data, 0);
    cmp("rst_pkt_cnt", pkt_cnt, 0);
    cmp("rst_err_cnt", err_cnt, 0);
    cmp("rst_err_status", err_status, 0);

    // Three clean 432-word packets, 20 idle cycles apart
    rst = 1'b0; rx_en = 1'b1;
    idle(5);
    for (int p = 0; p < 3; p++) begin
      send_burst(432, 0, -1, '0);
      idle(20);
    end
    check_regs("good3");
    cmp("first_latency", first_out - first_pad, 2);

    // Short burst
    cfg_data_length = 2'd0;
    clear_all();
    idle(20);
    send_burst(100, 7, -1, '0);
    check_regs("short");

    // Long burst
    clear_all();
    idle(20);
    send_burst(230, 0, -1, '0);
    check_regs("long");

    // Gap violation
    clear_all();
    idle(20);
    send_burst(216, 0, -1, '0);
    idle(5);
    send_burst(216, 0, -1, '0);
    check_regs("gap");

    // Pattern corruption at word 50
    clear_all();
    idle(20);
    send_burst(216, 0, 50, 18'h3FFFF);
    check_regs("pattern");

    // Enable raised mid-burst: burst dropped, next packet good
    clear_all();
    idle(20);
    rx_en = 1'b0;
    idle(3);
    for (int i = 0; i < 30; i++) begin
      rx_en          = (i >= 10);
      adc_data_valid = 1'b1;
      adc_data       = DW'($urandom);
      tick();
    end
    idle_run = 0;
    m_armed  = 1'b1;
    idle(20);
    send_burst(216, 5, -1, '0);
    check_regs("join");

    // Long flag set, then err_clr coincident with a new short flag
    idle(20);
    send_burst(240, 0, -1, '0);
    idle(20);
    send_burst(50, 0, -1, '0);
    err_clr = 1'b1;
    idle(1);
    err_clr  = 1'b0;
    m_status = 4'b0001;
    check_regs("clr_race");

    // Gap counter saturation at 255
    clear_all();
    cfg_idle_length = 8'd255;
    idle(260);
    send_burst(216, 0, -1, '0);
    idle(200);
    send_burst(216, 0, -1, '0);
    check_regs("gap_sat");

    // Randomized bursts
    clear_all();
    for (int it = 0; it < 25; it++) begin
      int sel, len, cidx;
      cfg_self_test   = 1'($urandom_range(0, 1));
      cfg_idle_length = 8'($urandom_range(0, 20));
      idle($urandom_range(1, 30));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       len = 1;
        1:       len = $urandom_range(2, 215);
        2:       len = 216;
        default: len = $urandom_range(217, 240);
      endcase
      cidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      send_burst(len, int'($urandom_range(0, 262143)), cidx, DW'($urandom));
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    cmp("scoreboard_drained", exp_q.size(), 0);
    check_regs("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
